delay_line_ctrl: RTL and testbench

//  Sequences the dual-port sample memory as a circular delay line for echo/delay effects.
//  Per audio-rate sample strobe, it reads the sample written DELAY samples ago and writes the new sample.
//  It then presents the delayed sample with a valid pulse.

---
 rtl/delay_pkg.sv | 17 +
 rtl/circ_sub.sv | 27 ++
 rtl/delay_line_ctrl.sv | 161 ++++++++++++++++
 tb/tb_delay_line_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and helpers for the circular delay-line controller family.
package delay_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } state_e;

  // Longest usable delay is one less than the memory depth.
  function automatic int unsigned clamp_delay(input int unsigned delay,
                                              input int unsigned size);
    return (delay > size - 1) ? size - 1 : delay;
  endfunction

endpackage

// File: rtl/circ_sub.sv
// Combinational modular subtract: rd_addr = (wr_ptr - d) mod Size, for d < Size.
module circ_sub #(
  parameter int unsigned AddrWidth = 15,
  parameter int unsigned Size      = 20000
) (
  input  logic [AddrWidth-1:0] wr_ptr_i,
  input  logic [AddrWidth-1:0] d_i,
  output logic [AddrWidth-1:0] rd_addr_o
);

  localparam logic [AddrWidth:0] SizeW = (AddrWidth + 1)'(Size);

  logic [AddrWidth:0] ptr_w, d_w, sum;

  // One extra bit so ptr + Size cannot overflow when Size == 2**AddrWidth.
  always_comb begin
    ptr_w = {1'b0, wr_ptr_i};
    d_w   = {1'b0, d_i};
    if (ptr_w >= d_w) begin
      sum = ptr_w - d_w;
    end else begin
      sum = ptr_w + SizeW - d_w;
    end
    rd_addr_o = AddrWidth'(sum);
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Sequences a dual-port RAM as a circular delay line: read the old sample, write the new one,
// then present the delayed sample with a one-cycle valid pulse.
module delay_line_ctrl import delay_pkg::*; #(
  parameter int unsigned DataWidth = 31,
  parameter int unsigned AddrWidth = 15,
  parameter int unsigned Size      = 20000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] sample_in_i,
  input  logic                 sample_valid_i,
  input  logic [AddrWidth-1:0] delay_i,
  input  logic                 clear_i,
  output logic [DataWidth-1:0] sample_out_o,
  output logic                 out_valid_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_waddr_o,
  output logic [AddrWidth-1:0] mem_raddr_o,
  output logic [DataWidth-1:0] mem_di_o,
  input  logic [DataWidth-1:0] mem_do_i
);

  localparam logic [AddrWidth:0]   SizeW   = (AddrWidth + 1)'(Size);
  localparam logic [AddrWidth-1:0] LastPtr = AddrWidth'(Size - 1);

  state_e               state_q, state_d;
  logic [DataWidth-1:0] sample_q, sample_d;
  logic [AddrWidth-1:0] d_q, d_d;
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth:0]   fill_q, fill_d;
  logic [AddrWidth-1:0] raddr_q, raddr_d;
  logic [AddrWidth-1:0] waddr_q, waddr_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] sample_out_q, sample_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 clear_pend_q, clear_pend_d;

  logic [AddrWidth-1:0] d_clamped;
  logic [AddrWidth-1:0] rd_addr;

  assign d_clamped = AddrWidth'(clamp_delay(32'(delay_i), Size));

  circ_sub #(
    .AddrWidth (AddrWidth),
    .Size      (Size)
  ) u_circ_sub (
    .wr_ptr_i  (wr_ptr_q),
    .d_i       (d_clamped),
    .rd_addr_o (rd_addr)
  );

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    d_d          = d_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    we_d         = 1'b0;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    overrun_d    = overrun_q;
    clear_pend_d = clear_pend_q;

    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          fill_d    = '0;
          overrun_d = 1'b0;
        end
        if (sample_valid_i) begin
          sample_d = sample_in_i;
          d_d      = d_clamped;
          raddr_d  = rd_addr;
          state_d  = StRd;
        end
      end
      StRd: begin
        waddr_d = wr_ptr_q;
        we_d    = 1'b1;
        state_d = StWr;
      end
      StWr: begin
        // RAM data is valid this cycle; the result appears while in StDone.
        if (d_q == '0) begin
          sample_out_d = sample_q;
        end else if (fill_q < {1'b0, d_q}) begin
          sample_out_d = '0;
        end else begin
          sample_out_d = mem_do_i;
        end
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        if (clear_pend_q || clear_i) begin
          fill_d = '0;
        end else if (fill_q < SizeW) begin
          fill_d = fill_q + 1'b1;
        end
        clear_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      if (sample_valid_i) begin
        overrun_d = 1'b1;
      end
      if (clear_i && state_q != StDone) begin
        clear_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sample_q     <= '0;
      d_q          <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      we_q         <= 1'b0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      d_q          <= d_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      we_q         <= we_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  assign sample_out_o = sample_out_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign overrun_o    = overrun_q;
  assign mem_we_o     = we_q;
  assign mem_waddr_o  = waddr_q;
  assign mem_raddr_o  = raddr_q;
  assign mem_di_o     = sample_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl with a behavioural 1-cycle-read dual-port RAM.
module tb_delay_line_ctrl;

  localparam int DW   = 16;
  localparam int AW   = 5;
  localparam int SIZE = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic [AW-1:0] delay = '0;
  logic          clear = 1'b0;
  logic [DW-1:0] sample_out;
  logic          out_valid, busy, overrun, mem_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_di, mem_do;

  delay_line_ctrl #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .Size      (SIZE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sample_in_i    (sample_in),
    .sample_valid_i (sample_valid),
    .delay_i        (delay),
    .clear_i        (clear),
    .sample_out_o   (sample_out),
    .out_valid_o    (out_valid),
    .busy_o         (busy),
    .overrun_o      (overrun),
    .mem_we_o       (mem_we),
    .mem_waddr_o    (mem_waddr),
    .mem_raddr_o    (mem_raddr),
    .mem_di_o       (mem_di),
    .mem_do_i       (mem_do)
  );

  always #5 clk = ~clk;

  // RAM starts full of garbage so stale history would show up on the output.
  logic [DW-1:0] mem [SIZE];
  bit            mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= DW'($urandom_range(1, 65535));
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_waddr[3:0]] <= mem_di;
    end
    mem_do <= mem[mem_raddr[3:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every written sample in order, plus the valid-history count.
  logic [DW-1:0] hist[$];
  int            fill = 0;
  int            wcount = 0;
  logic [DW-1:0] exp_q[$];
  int            expcyc_q[$];
  int            wexp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("sample_out", 32'(sample_out), 32'(exp_q.pop_front()));
          check("out_latency", 32'(cyc), 32'(expcyc_q.pop_front()));
        end
      end
      if (mem_we) begin
        if (wexp_q.size() == 0) check("unexpected_mem_we", 32'(mem_we), 32'd0);
        else check("mem_waddr", 32'(mem_waddr), 32'(wexp_q.pop_front()));
      end
      if (busy && mem_raddr >= AW'(SIZE)) check("raddr_range", 32'(mem_raddr), 32'(SIZE - 1));
    end
  end

  task automatic send(input logic [DW-1:0] s, input int dly, input bit clr, input int post);
    int            d;
    logic [DW-1:0] e;
    @(posedge clk); #1;
    sample_in    = s;
    delay        = AW'(dly);
    sample_valid = 1'b1;
    clear        = clr;
    if (clr) fill = 0;
    d = (dly > SIZE - 1) ? SIZE - 1 : dly;
    if (d == 0)         e = s;
    else if (fill < d)  e = '0;
    else                e = hist[hist.size() - d];
    exp_q.push_back(e);
    expcyc_q.push_back(cyc + 3);
    wexp_q.push_back(wcount % SIZE);
    hist.push_back(s);
    wcount++;
    if (fill < SIZE) fill++;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
    repeat (post) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size() + wexp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    expcyc_q.delete();
    wexp_q.delete();
    hist.delete();
    fill   = 0;
    wcount = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    rst_n = 1'b1;

    // 1: delay 3, samples 1..6
    for (int n = 1; n <= 6; n++) send(DW'(n), 3, 1'b0, 2);
    drain();

    // 2: bypass after a fresh reset writes addresses 0,1
    do_reset();
    send(DW'(7), 0, 1'b0, 2);
    send(DW'(8), 0, 1'b0, 2);
    drain();

    // 3: maximum delay across several wraps
    do_reset();
    for (int n = 1; n <= 40; n++) send(DW'(n), SIZE - 1, 1'b0, 2);
    drain();

    // 4: over-range delay clamps
    for (int n = 0; n < 8; n++) send(DW'($urandom), 20, 1'b0, 2);
    drain();

    // 5: overrun then clear
    send(DW'(16'h1234), 4, 1'b0, 0);
    @(posedge clk); #1;
    sample_in    = DW'(16'hBEEF);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    drain();
    check("overrun_set", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    clear = 1'b1;
    fill  = 0;
    @(posedge clk); #1;
    clear = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);
    for (int n = 0; n < 6; n++) send(DW'($urandom), 3, 1'b0, 2);
    drain();

    // random mix of delays, gaps and clear-with-strobe
    for (int n = 0; n < 40; n++) begin
      send(DW'($urandom), $urandom_range(0, 20), ($urandom_range(0, 9) == 0),
           2 + $urandom_range(0, 2));
    end
    drain();

    // 6: reset during WR aborts the write at once
    @(posedge clk); #1;
    sample_in    = DW'(16'h5A5A);
    delay        = AW'(2);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    check("wr_state_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    do_reset();
    send(DW'(16'h0777), 2, 1'b0, 2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
